// File: rtl/winograd2d_tile_feeder_if.sv
// Column/kernel/tile handshake bundle for the winograd2d tile feeder.
// slave = feeder side, master = source/core side.
interface winograd2d_tile_feeder_if #(
   parameter int DATA_W = 32
);
   logic                     in_valid;
   logic                     in_ready;
   logic signed [DATA_W-1:0] in_r1_x, in_r2_x, in_r3_x, in_r4_x;
   logic                     w_wr_en;
   logic [1:0]               w_wr_col;
   logic signed [DATA_W-1:0] w_wr_1, w_wr_2, w_wr_3;
   logic signed [DATA_W-1:0] r1_x, r2_x, r3_x, r4_x;
   logic signed [DATA_W-1:0] r1_w, r2_w, r3_w;
   logic                     out_valid;
   logic                     tile_start;
   logic                     tile_last;
   logic                     strip_done;

   modport slave (
      input  in_valid, in_r1_x, in_r2_x, in_r3_x, in_r4_x,
      input  w_wr_en, w_wr_col, w_wr_1, w_wr_2, w_wr_3,
      output in_ready,
      output r1_x, r2_x, r3_x, r4_x, r1_w, r2_w, r3_w,
      output out_valid, tile_start, tile_last, strip_done
   );

   modport master (
      output in_valid, in_r1_x, in_r2_x, in_r3_x, in_r4_x,
      output w_wr_en, w_wr_col, w_wr_1, w_wr_2, w_wr_3,
      input  in_ready,
      input  r1_x, r2_x, r3_x, r4_x, r1_w, r2_w, r3_w,
      input  out_valid, tile_start, tile_last, strip_done
   );
endinterface

// File: rtl/winograd2d_tile_feeder.sv
// winograd2d F(2x2,3x3) tile feeder: buffers a 4-row strip and replays stride-2 4x4 tiles
// with a shadowed 3x3 kernel. Define WINO_FEED_PAD_EN for SAME zero padding on both strip edges.
module winograd2d_tile_feeder #(
   parameter int DATA_W  = 32,
   parameter int STRIP_W = 8
) (
   input logic                     clk,
   input logic                     rst,
   winograd2d_tile_feeder_if.slave bus
);
   localparam int              CC_W   = $clog2(STRIP_W + 1);
   localparam logic [CC_W-1:0] CC_END = CC_W'(STRIP_W);
`ifdef WINO_FEED_PAD_EN
   localparam logic [2:0]      BC_START = 3'd1;
`else
   localparam logic [2:0]      BC_START = 3'd0;
`endif

   generate
      if (STRIP_W < 4 || (STRIP_W % 2) != 0) begin : g_bad_strip
         $error("winograd2d_tile_feeder: STRIP_W must be even and >= 4");
      end
   endgenerate

   typedef logic signed [DATA_W-1:0] pix_t;
   typedef enum logic {FILL, EMIT} state_t;

   state_t          st, st_n;
   logic [1:0]      ph, ph_n;
   logic [2:0]      bc, bc_n;
   logic [CC_W-1:0] cc, cc_n;
   pix_t            colbuf [4][4];
   pix_t            buf_n  [4][4];
   pix_t            kk     [3][3];
   pix_t            kk_n   [3][3];
   pix_t            sk     [3][3];
   pix_t            sk_n   [3][3];
   pix_t            x_q [4];
   pix_t            x_n [4];
   pix_t            w_q [3];
   pix_t            w_n [3];
   logic            ov_q, ov_n, ts_q, ts_n, tl_q, tl_n, sd_q, sd_n;
   logic            accept;

   assign bus.in_ready = (st == FILL) && (bc < 3'd4) && (cc < CC_END) && !rst;
   assign accept       = bus.in_valid && bus.in_ready;

   // Output registers load from the post-edge buffer/shadow view, so the
   // column written on the entering edge is already visible at phase p.
   always_comb begin
      st_n  = st;
      ph_n  = ph;
      bc_n  = bc;
      cc_n  = cc;
      buf_n = colbuf;
      kk_n  = kk;
      sk_n  = sk;
      ov_n  = 1'b0;
      ts_n  = 1'b0;
      tl_n  = 1'b0;
      sd_n  = 1'b0;
      x_n   = '{default: '0};
      w_n   = '{default: '0};

      if (bus.w_wr_en) begin
         case (bus.w_wr_col)
            2'd0:    kk_n[0] = '{bus.w_wr_1, bus.w_wr_2, bus.w_wr_3};
            2'd1:    kk_n[1] = '{bus.w_wr_1, bus.w_wr_2, bus.w_wr_3};
            2'd2:    kk_n[2] = '{bus.w_wr_1, bus.w_wr_2, bus.w_wr_3};
            default: ;
         endcase
      end

      case (st)
         FILL: begin
            if (accept) begin
               buf_n[bc[1:0]] = '{bus.in_r1_x, bus.in_r2_x, bus.in_r3_x, bus.in_r4_x};
               bc_n = bc + 3'd1;
               cc_n = cc + CC_W'(1);
            end
`ifdef WINO_FEED_PAD_EN
            else if (cc == CC_END && bc < 3'd4) begin
               buf_n[bc[1:0]] = '{default: '0};
               bc_n = bc + 3'd1;
            end
`endif
            if (bc_n == 3'd4) begin
               st_n = EMIT;
               ph_n = 2'd0;
               sk_n = kk;
            end
         end
         EMIT: begin
            if (ph == 2'd3) begin
               st_n = FILL;
               if (cc == CC_END) begin
                  bc_n = BC_START;
                  cc_n = '0;
                  sd_n = 1'b1;
`ifdef WINO_FEED_PAD_EN
                  buf_n[0] = '{default: '0};
`endif
               end else begin
                  buf_n[0] = colbuf[2];
                  buf_n[1] = colbuf[3];
                  bc_n     = 3'd2;
               end
            end else begin
               ph_n = ph + 2'd1;
            end
         end
         default: ;
      endcase

      if (st_n == EMIT) begin
         ov_n = 1'b1;
         ts_n = (ph_n == 2'd0);
         tl_n = (cc_n == CC_END);
         x_n  = buf_n[ph_n];
         case (ph_n)
            2'd0:    w_n = sk_n[0];
            2'd1:    w_n = sk_n[1];
            2'd2:    w_n = sk_n[2];
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st     <= FILL;
         ph     <= '0;
         bc     <= BC_START;
         cc     <= '0;
         colbuf <= '{default: '0};
         kk     <= '{default: '0};
         sk     <= '{default: '0};
         x_q    <= '{default: '0};
         w_q    <= '{default: '0};
         ov_q   <= 1'b0;
         ts_q   <= 1'b0;
         tl_q   <= 1'b0;
         sd_q   <= 1'b0;
      end else begin
         st     <= st_n;
         ph     <= ph_n;
         bc     <= bc_n;
         cc     <= cc_n;
         colbuf <= buf_n;
         kk     <= kk_n;
         sk     <= sk_n;
         x_q    <= x_n;
         w_q    <= w_n;
         ov_q   <= ov_n;
         ts_q   <= ts_n;
         tl_q   <= tl_n;
         sd_q   <= sd_n;
      end
   end

   assign bus.r1_x       = x_q[0];
   assign bus.r2_x       = x_q[1];
   assign bus.r3_x       = x_q[2];
   assign bus.r4_x       = x_q[3];
   assign bus.r1_w       = w_q[0];
   assign bus.r2_w       = w_q[1];
   assign bus.r3_w       = w_q[2];
   assign bus.out_valid  = ov_q;
   assign bus.tile_start = ts_q;
   assign bus.tile_last  = tl_q;
   assign bus.strip_done = sd_q;
endmodule

// File: tb/tb_winograd2d_tile_feeder.sv
// Directed, table-driven bench for winograd2d_tile_feeder (default build: STRIP_W=8;
// with WINO_FEED_PAD_EN: STRIP_W=4 padded strip).
`timescale 1ns/1ps
module tb_winograd2d_tile_feeder;
   localparam int DW = 32;
`ifdef WINO_FEED_PAD_EN
   localparam int SW = 4;
`else
   localparam int SW = 8;
`endif

   typedef logic signed [DW-1:0] col_t [4];
   typedef logic signed [DW-1:0] kc_t [3];
   typedef struct {
      logic vld; int ci; logic wen;
      logic e_rdy; logic e_ov; logic e_ts; logic e_tl; logic e_sd;
      int   xi;  // expected x column index, -1 = zero column
      int   wk;  // expected kernel column index, -1 = zero
   } vec_t;

   logic clk, rst;
   int   n_pass, n_total, hs;
   col_t cols [8];
   col_t dcols [12];
   kc_t  kern [4];
   col_t zc;
   kc_t  zk;
   vec_t tbl [$];

   winograd2d_tile_feeder_if #(.DATA_W(DW)) bus ();

   winograd2d_tile_feeder #(.DATA_W(DW), .STRIP_W(SW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(string nm, longint act, longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
   endtask

   task automatic chk_cycle(string tag, logic e_rdy, logic e_ov, logic e_ts, logic e_tl,
                            logic e_sd, col_t ex, kc_t ew);
      chk({tag, " in_ready"},   bus.in_ready,   e_rdy);
      chk({tag, " out_valid"},  bus.out_valid,  e_ov);
      chk({tag, " tile_start"}, bus.tile_start, e_ts);
      chk({tag, " tile_last"},  bus.tile_last,  e_tl);
      chk({tag, " strip_done"}, bus.strip_done, e_sd);
      chk({tag, " r1_x"}, bus.r1_x, ex[0]);
      chk({tag, " r2_x"}, bus.r2_x, ex[1]);
      chk({tag, " r3_x"}, bus.r3_x, ex[2]);
      chk({tag, " r4_x"}, bus.r4_x, ex[3]);
      chk({tag, " r1_w"}, bus.r1_w, ew[0]);
      chk({tag, " r2_w"}, bus.r2_w, ew[1]);
      chk({tag, " r3_w"}, bus.r3_w, ew[2]);
   endtask

   task automatic set_col(col_t c);
      bus.in_r1_x = c[0];
      bus.in_r2_x = c[1];
      bus.in_r3_x = c[2];
      bus.in_r4_x = c[3];
   endtask

   task automatic wr_k(int col, int a, int b, int c);
      @(negedge clk);
      bus.w_wr_en  = 1'b1;
      bus.w_wr_col = 2'(col);
      bus.w_wr_1   = DW'(a);
      bus.w_wr_2   = DW'(b);
      bus.w_wr_3   = DW'(c);
      chk_cycle($sformatf("kwrite%0d", col), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, zc, zk);
   endtask

   function automatic vec_t mk(logic vld, int ci, logic wen, logic rdy, logic ov, logic ts,
                               logic tl, logic sd, int xi, int wk);
      vec_t v;
      v.vld = vld; v.ci = ci; v.wen = wen;
      v.e_rdy = rdy; v.e_ov = ov; v.e_ts = ts; v.e_tl = tl; v.e_sd = sd;
      v.xi = xi; v.wk = wk;
      return v;
   endfunction

   // One row per cycle: drive inputs at the falling edge, check the cycle's outputs.
   task automatic run_table(string tag);
      col_t ex;
      kc_t  ew;
      hs = 0;
      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         bus.in_valid = tbl[i].vld;
         set_col(cols[tbl[i].ci]);
         bus.w_wr_en  = tbl[i].wen;
         bus.w_wr_col = 2'd0;
         bus.w_wr_1   = 9;
         bus.w_wr_2   = 9;
         bus.w_wr_3   = 9;
         if (tbl[i].vld && bus.in_ready) hs++;
         ex = (tbl[i].xi < 0) ? zc : cols[tbl[i].xi];
         ew = (tbl[i].wk < 0) ? zk : kern[tbl[i].wk];
         chk_cycle($sformatf("%s[%0d]", tag, i), tbl[i].e_rdy, tbl[i].e_ov, tbl[i].e_ts,
                   tbl[i].e_tl, tbl[i].e_sd, ex, ew);
      end
      bus.in_valid = 1'b0;
      bus.w_wr_en  = 1'b0;
   endtask

`ifndef WINO_FEED_PAD_EN
   task automatic fill(string tag, col_t c, logic vld, logic e_rdy);
      @(negedge clk);
      bus.in_valid = vld;
      set_col(c);
      chk_cycle(tag, e_rdy, 1'b0, 1'b0, 1'b0, 1'b0, zc, zk);
   endtask

   task automatic tile(string tag, int first, int k0, int k1, int k2, logic last);
      int ki [3];
      ki = '{k0, k1, k2};
      for (int p = 0; p < 4; p++) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
         chk_cycle($sformatf("%s p%0d", tag, p), 1'b0, 1'b1, logic'(p == 0), last, 1'b0,
                   dcols[first + p], (p < 3) ? kern[ki[p]] : zk);
      end
   endtask
`endif

   initial begin
      n_pass = 0;
      n_total = 0;
      zc = '{default: '0};
      zk = '{default: '0};
      for (int k = 0; k < 8; k++) cols[k] = '{DW'(3 + k), DW'(1 + k), DW'(5 + k), DW'(3 + k)};
      for (int k = 0; k < 12; k++) dcols[k] = '{DW'(100 + k), DW'(-k), DW'(7 * k), DW'(50 - k)};
      kern[0] = '{0, -2, -4};
      kern[1] = '{-2, -4, -8};
      kern[2] = '{-4, -6, -12};
      kern[3] = '{9, 9, 9};

      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.w_wr_en  = 1'b0;
      bus.w_wr_col = 2'd0;
      bus.w_wr_1 = '0; bus.w_wr_2 = '0; bus.w_wr_3 = '0;
      set_col(zc);
      @(negedge clk);
      @(negedge clk);
      chk_cycle("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, zc, zk);
      rst = 1'b0;

      wr_k(0, 0, -2, -4);
      wr_k(1, -2, -4, -8);
      wr_k(2, -4, -6, -12);
      wr_k(3, 77, 77, 77);  // index 3 must be ignored

`ifndef WINO_FEED_PAD_EN
      //        vld ci wen rdy ov ts tl sd  xi  wk
      tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, -1, -1));
      tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, -1, -1));
      tbl.push_back(mk(1, 2, 0, 1, 0, 0, 0, 0, -1, -1));
      tbl.push_back(mk(1, 3, 0, 1, 0, 0, 0, 0, -1, -1));
      tbl.push_back(mk(1, 4, 0, 0, 1, 1, 0, 0,  0,  0));
      tbl.push_back(mk(1, 4, 1, 0, 1, 0, 0, 0,  1,  1));  // K0 <= 9s mid-tile
      tbl.push_back(mk(1, 4, 0, 0, 1, 0, 0, 0,  2,  2));
      tbl.push_back(mk(1, 4, 0, 0, 1, 0, 0, 0,  3, -1));
      tbl.push_back(mk(1, 4, 0, 1, 0, 0, 0, 0, -1, -1));
      tbl.push_back(mk(1, 5, 0, 1, 0, 0, 0, 0, -1, -1));
      tbl.push_back(mk(1, 6, 0, 0, 1, 1, 0, 0,  2,  3));
      tbl.push_back(mk(1, 6, 0, 0, 1, 0, 0, 0,  3,  1));
      tbl.push_back(mk(1, 6, 0, 0, 1, 0, 0, 0,  4,  2));
      tbl.push_back(mk(1, 6, 0, 0, 1, 0, 0, 0,  5, -1));
      tbl.push_back(mk(1, 6, 0, 1, 0, 0, 0, 0, -1, -1));
      tbl.push_back(mk(1, 7, 0, 1, 0, 0, 0, 0, -1, -1));
      tbl.push_back(mk(1, 7, 0, 0, 1, 1, 1, 0,  4,  3));
      tbl.push_back(mk(1, 7, 0, 0, 1, 0, 1, 0,  5,  1));
      tbl.push_back(mk(1, 7, 0, 0, 1, 0, 1, 0,  6,  2));
      tbl.push_back(mk(1, 7, 0, 0, 1, 0, 1, 0,  7, -1));
      tbl.push_back(mk(0, 7, 0, 1, 0, 0, 0, 1, -1, -1));
      tbl.push_back(mk(0, 7, 0, 1, 0, 0, 0, 0, -1, -1));
      run_table("strip");
      chk("strip handshakes", hs, 8);

      // Stall: one refill column, then in_valid low for 5 cycles.
      for (int k = 0; k < 4; k++) fill($sformatf("s2 fill%0d", k), dcols[k], 1'b1, 1'b1);
      tile("s2 t0", 0, 3, 1, 2, 1'b0);
      fill("s2 refill4", dcols[4], 1'b1, 1'b1);
      for (int k = 0; k < 5; k++) fill($sformatf("s2 stall%0d", k), dcols[5], 1'b0, 1'b1);
      fill("s2 refill5", dcols[5], 1'b1, 1'b1);
      tile("s2 t1", 2, 3, 1, 2, 1'b0);
      fill("s2 refill6", dcols[6], 1'b1, 1'b1);
      fill("s2 refill7", dcols[7], 1'b1, 1'b1);

      // Async reset asserted during phase 2 of the last tile.
      for (int p = 0; p < 3; p++) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
         chk_cycle($sformatf("s2 t2 p%0d", p), 1'b0, 1'b1, logic'(p == 0), 1'b1, 1'b0,
                   dcols[4 + p], kern[(p == 0) ? 3 : p]);
      end
      #2 rst = 1'b1;
      #1 chk_cycle("async rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, zc, zk);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) fill($sformatf("s3 fill%0d", k), dcols[8 + k], 1'b1, 1'b1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk_cycle("s3 p0", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, dcols[8], zk);
`else
      //        vld ci wen rdy ov ts tl sd  xi  wk
      tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, -1, -1));
      tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, -1, -1));
      tbl.push_back(mk(1, 2, 0, 1, 0, 0, 0, 0, -1, -1));
      tbl.push_back(mk(1, 3, 0, 0, 1, 1, 0, 0, -1,  0));
      tbl.push_back(mk(1, 3, 0, 0, 1, 0, 0, 0,  0,  1));
      tbl.push_back(mk(1, 3, 0, 0, 1, 0, 0, 0,  1,  2));
      tbl.push_back(mk(1, 3, 0, 0, 1, 0, 0, 0,  2, -1));
      tbl.push_back(mk(1, 3, 0, 1, 0, 0, 0, 0, -1, -1));
      tbl.push_back(mk(1, 3, 0, 0, 0, 0, 0, 0, -1, -1));  // right pad inserted
      tbl.push_back(mk(1, 3, 0, 0, 1, 1, 1, 0,  1,  0));
      tbl.push_back(mk(1, 3, 0, 0, 1, 0, 1, 0,  2,  1));
      tbl.push_back(mk(1, 3, 0, 0, 1, 0, 1, 0,  3,  2));
      tbl.push_back(mk(1, 3, 0, 0, 1, 0, 1, 0, -1, -1));
      tbl.push_back(mk(0, 3, 0, 1, 0, 0, 0, 1, -1, -1));
      tbl.push_back(mk(0, 3, 0, 1, 0, 0, 0, 0, -1, -1));
      run_table("pad");
      chk("pad handshakes", hs, 4);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
